// File: rtl/rf_xfer_ctrl_if.sv
// Bundle of command, load-stream, register-file and dump-stream signals for rf_xfer_ctrl.
// master: the side that issues commands, feeds the load stream, owns the register file, sinks the dump stream.
// slave: the transfer controller itself.
interface rf_xfer_ctrl_if #(
    parameter int pw = 4
);
    logic          cmd_load;
    logic          cmd_dump;
    logic [pw-1:0] base_addr;
    logic [pw:0]   count;
    logic          busy;
    logic          done;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          rf_wr_en;
    logic [pw-1:0] rf_wr_addr;
    logic [7:0]    rf_dat_in;
    logic [pw-1:0] rf_rd_addr;
    logic [7:0]    rf_rd_data;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready;

    modport master (
        output cmd_load, cmd_dump, base_addr, count,
        output s_data, s_valid, rf_rd_data, m_ready,
        input  busy, done, s_ready, rf_wr_en, rf_wr_addr, rf_dat_in,
        input  rf_rd_addr, m_data, m_valid
    );

    modport slave (
        input  cmd_load, cmd_dump, base_addr, count,
        input  s_data, s_valid, rf_rd_data, m_ready,
        output busy, done, s_ready, rf_wr_en, rf_wr_addr, rf_dat_in,
        output rf_rd_addr, m_data, m_valid
    );
endinterface

// File: rtl/rf_xfer_ctrl.sv
// Moves a byte stream into a register file (LOAD) or a register-file range out to a byte stream (DUMP).
// Latency: load writes land on the handshake edge; first dump byte valid two cycles after the command.
// Backpressure: s_ready only in LOAD; dump output register holds m_data/m_valid while m_ready is low.
module rf_xfer_ctrl #(
    parameter int pw = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    rf_xfer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [pw:0] DEPTH = {1'b1, {pw{1'b0}}};
    localparam logic [pw:0] ONE   = {{pw{1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [pw-1:0] ptr_q, ptr_d;
    logic [pw:0]   rem_q, rem_d;
    logic [pw:0]   cnt_clamped;
    logic [7:0]    m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;

    // A transfer never covers more than the whole register file.
    assign cnt_clamped = (bus.count > DEPTH) ? DEPTH : bus.count;

    // Stream and register-file side outputs. Load-side strobes are gated by
    // rst_n so a byte presented in the reset cycle is never written.
    assign bus.busy       = (state_q == LOAD) || (state_q == DUMP);
    assign bus.done       = (state_q == DONE);
    assign bus.s_ready    = (state_q == LOAD) && rst_n;
    assign bus.rf_wr_en   = (state_q == LOAD) && bus.s_valid && rst_n;
    assign bus.rf_wr_addr = ptr_q;
    assign bus.rf_dat_in  = bus.s_data;
    assign bus.rf_rd_addr = ptr_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_valid    = m_valid_q;

    // Next-state logic: command capture, pointer/remaining bookkeeping, dump output register.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_load || bus.cmd_dump) begin
                    ptr_d = bus.base_addr;
                    rem_d = cnt_clamped;
                    if (cnt_clamped == '0) begin
                        state_d = DONE;
                    end else if (bus.cmd_load) begin
                        state_d = LOAD;
                    end else begin
                        state_d = DUMP;
                    end
                end
            end
            LOAD: begin
                if (bus.s_valid) begin
                    ptr_d = ptr_q + 1'b1;
                    rem_d = rem_q - ONE;
                    if (rem_q == ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DUMP: begin
                // remaining counts bytes still to be read; once it hits zero the
                // only thing left is the final output-register handshake.
                if ((rem_q != '0) && (!m_valid_q || bus.m_ready)) begin
                    m_data_d  = bus.rf_rd_data;
                    m_valid_d = 1'b1;
                    ptr_d     = ptr_q + 1'b1;
                    rem_d     = rem_q - ONE;
                end else if (m_valid_q && bus.m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
        end
    end
endmodule

// File: doc/rf_xfer_ctrl.md
RF_XFER_CTRL -- requirements
Module: rf_xfer_ctrl

Interface
REQ-001 SHALL have parameter: pw, 4, register file address pointer width (depth 2**pw, 8-bit entries).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: cmd_load  input  1  start load (byte stream -> register file), sampled in IDLE only.
REQ-005 SHALL have port: cmd_dump  input  1  start dump (register file -> byte stream), sampled in IDLE only.
REQ-006 SHALL have port: base_addr  input  pw  first register address, sampled with command.
REQ-007 SHALL have port: count  input  pw+1  number of bytes to transfer, sampled with command.
REQ-008 SHALL have port: busy  output  1  high in LOAD or DUMP.
REQ-009 SHALL have port: done  output  1  one-cycle pulse on transfer completion.
REQ-010 SHALL have port: s_data  input  8  load stream byte.
REQ-011 SHALL have port: s_valid  input  1  load byte valid.
REQ-012 SHALL have port: s_ready  output  1  load byte accepted when s_valid and s_ready both high.
REQ-013 SHALL have port: rf_wr_en  output  1  register file write enable.
REQ-014 SHALL have port: rf_wr_addr  output  pw  register file write address.
REQ-015 SHALL have port: rf_dat_in  output  8  register file write data.
REQ-016 SHALL have port: rf_rd_addr  output  pw  register file read address (combinational read path).
REQ-017 SHALL have port: rf_rd_data  input  8  register file read data for rf_rd_addr, same cycle.
REQ-018 SHALL have port: m_data  output  8  dump stream byte (registered).
REQ-019 SHALL have port: m_valid  output  1  dump byte valid.
REQ-020 SHALL have port: m_ready  input  1  dump byte accepted when m_valid and m_ready both high.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD, DUMP, DONE; IDLE->LOAD on cmd_load, IDLE->DUMP on cmd_dump, LOAD/DUMP->DONE after last byte accepted, DONE->IDLE unconditionally after one cycle.
REQ-022 SHALL give cmd_load priority when cmd_load and cmd_dump are both high in IDLE; commands outside IDLE are ignored.
REQ-023 SHALL, on command in IDLE, latch pointer=base_addr and remaining=min(count, 2**pw); count 0 goes IDLE->DONE with no writes and no m_valid.
REQ-024 SHALL advance the pointer modulo 2**pw per accepted byte (base 14, count 4 -> addresses 14,15,0,1).
REQ-025 SHALL drive s_ready=1 only in LOAD; rf_wr_en = LOAD and s_valid (combinational), rf_wr_addr=pointer, rf_dat_in=s_data; write lands at the same edge as the handshake.
REQ-026 SHALL keep rf_wr_en=0 in all states other than LOAD.
REQ-027 SHALL drive rf_rd_addr=pointer in DUMP and load m_data from rf_rd_data, setting m_valid, whenever remaining>0 and (m_valid=0 or m_ready=1).
REQ-028 SHALL hold m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-029 SHALL produce first m_valid two cycles after the cmd_dump cycle and sustain one byte per cycle with m_ready held high.
REQ-030 SHALL clear m_valid when the last byte is accepted and leave DUMP in that cycle; done=1 only in DONE; busy=1 only in LOAD/DUMP.

Reset
REQ-031 SHALL, with rst_n=0 at a posedge, enter IDLE and set busy, done, s_ready, rf_wr_en, m_valid to 0, m_data, pointer, remaining to 0, in any state including mid-transfer.
REQ-032 SHALL not issue any write for a byte presented during the reset cycle; register contents already written stay as written.

Verification
REQ-033 SHALL cover: cmd_load, base 2, count 3, s_data A1,B2,C3 with s_valid always high -> writes r2=A1,r3=B2,r4=C3 on consecutive edges, done pulse one cycle after last write.
REQ-034 SHALL cover: cmd_dump, base 14, count 4, m_ready high -> m_data core[14],[15],[0],[1] on 4 consecutive cycles starting 2 cycles after command, then done.
REQ-035 SHALL cover: dump with m_ready low for 3 cycles on the second byte -> m_data/m_valid held constant, no byte lost or duplicated.
REQ-036 SHALL cover: cmd_load and cmd_dump together in IDLE, count 0 -> load taken, direct DONE, no rf_wr_en, done pulse next cycle.
REQ-037 SHALL cover: rst_n low after 2 of 5 load bytes -> IDLE next cycle, all outputs 0, only first 2 registers modified, cmd_dump mid-transfer ignored beforehand.
